// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the fetch PC, issues single-outstanding word reads to a
// variable-latency instruction memory and buffers returned words with their PCs in a FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    stale_addr_q, stale_addr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [63:0]    mem_q [DEPTH];
    logic [63:0]    mem_d [DEPTH];

    logic           push;
    logic           pop;
    logic           space;
    logic [31:0]    redirect_pc_al;

    assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
    assign pop            = (count_q != '0) && instr_ready;
    assign push           = (state_q == StWait) && imem_ack && !redirect;

    // FIFO bookkeeping; a redirect flushes everything at the edge, even a same-cycle push.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {fetch_pc_q, imem_rdata};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    assign space = count_d < CW'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end else if (space) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                    if (imem_ack) begin
                        state_d = StIdle;
                    end else begin
                        stale_addr_d = fetch_pc_q;
                        state_d      = StDiscard;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = space ? StWait : StIdle;
                end
            end
            StDiscard: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (imem_ack) begin
                    state_d = space ? StWait : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == StWait) || (state_q == StDiscard);
        imem_addr   = (state_q == StDiscard) ? stale_addr_q : fetch_pc_q;
        instr_valid = (count_q != '0);
        instr       = mem_q[rd_ptr_q][31:0];
        instr_pc    = mem_q[rd_ptr_q][63:32];
    end

endmodule
